bram_port_arbiter: RTL and testbench

Parametrised arbiter that shares one true-dual-port frame BRAM between a single burst writer (frame acquisition) and NUM_CH read channels (2D scan, 3D scan, frame analyzer, …). Port A belongs to the writer for the whole burst and serves reads otherwise. Port B serves reads only. Read data is routed back to the requesting channel through a latency-matched tag pipeline. The block sits between the acquisition write path, the DA scan generators and the BRAM primitive.

---
 rtl/bram_port_arbiter_pkg.sv | 68 ++++++
 rtl/bram_port_arbiter_if.sv | 45 ++++
 rtl/bram_port_arbiter_rd_tag_pipe.sv | 33 +++
 rtl/bram_port_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_bram_port_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bram_port_arbiter_pkg.sv
// Shared definitions for the frame BRAM port arbiter.
// Holds the write-FSM state encoding, the round-robin pick helper, the
// channel-id width and the read tag record carried through the latency pipe.
package bram_arb_pkg;

    // Write-side FSM: IDLE leaves port A free for reads, WR_BURST reserves it.
    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WR_BURST = 1'b1
    } arb_state_t;

    // Upper bound on the channel count; sizes the shared helpers and channel ids.
    localparam int unsigned MAX_CH  = 16;
    localparam int unsigned CH_ID_W = $clog2(MAX_CH);

    typedef logic [CH_ID_W-1:0] ch_id_t;

    // Result of a round-robin search.
    typedef struct packed {
        logic   found;
        ch_id_t idx;
    } rr_pick_t;

    // Tag travelling alongside a BRAM read until its data appears.
    typedef struct packed {
        logic   valid;
        ch_id_t ch_id;
    } rd_tag_t;

    // First set bit of req at or after ptr, wrapping at num_ch.
    function automatic rr_pick_t rr_pick(
        input logic [MAX_CH-1:0] req,
        input ch_id_t            ptr,
        input logic [CH_ID_W:0]  num_ch
    );
        rr_pick_t         res;
        logic [CH_ID_W:0] idx;
        res.found = 1'b0;
        res.idx   = '0;
        for (int unsigned i = 0; i < MAX_CH; i++) begin
            idx = {1'b0, ptr} + i[CH_ID_W:0];
            if (idx >= num_ch) begin
                idx = idx - num_ch;
            end else begin
                idx = idx;
            end
            if (!res.found && (i[CH_ID_W:0] < num_ch) && req[idx[CH_ID_W-1:0]]) begin
                res.found = 1'b1;
                res.idx   = idx[CH_ID_W-1:0];
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Channel index following c, wrapping to 0 after num_ch-1.
    function automatic ch_id_t ch_inc(input ch_id_t c, input logic [CH_ID_W:0] num_ch);
        logic [CH_ID_W:0] n;
        n = {1'b0, c} + {{CH_ID_W{1'b0}}, 1'b1};
        if (n >= num_ch) begin
            return '0;
        end else begin
            return n[CH_ID_W-1:0];
        end
    endfunction

endpackage

// File: rtl/bram_port_arbiter_if.sv
// Bus bundle between the BRAM port arbiter and its neighbours.
// Groups the burst write port, the NUM_CH read channels and both BRAM ports.
//   slave  : arbiter view (consumes write/read requests and BRAM read data)
//   master : environment view (acquisition writer, scan channels, BRAM)
interface bram_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int NUM_CH = 3
);
    // Burst writer
    logic                     wr_valid;
    logic                     wr_last;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     wr_busy;
    logic                     wr_done;
    // Read channels, channel i at [i*W +: W]
    logic [NUM_CH-1:0]        rd_req;
    logic [NUM_CH*ADDR_W-1:0] rd_addr;
    logic [NUM_CH-1:0]        rd_gnt;
    logic [NUM_CH-1:0]        rd_valid;
    logic [NUM_CH*DATA_W-1:0] rd_data;
    // BRAM port A (writer or reader) and port B (reader only)
    logic                     ena;
    logic                     wea;
    logic [ADDR_W-1:0]        addra;
    logic [DATA_W-1:0]        dina;
    logic [DATA_W-1:0]        douta;
    logic                     enb;
    logic [ADDR_W-1:0]        addrb;
    logic [DATA_W-1:0]        doutb;

    modport slave (
        input  wr_valid, wr_last, wr_addr, wr_data, rd_req, rd_addr, douta, doutb,
        output wr_busy, wr_done, rd_gnt, rd_valid, rd_data,
               ena, wea, addra, dina, enb, addrb
    );

    modport master (
        output wr_valid, wr_last, wr_addr, wr_data, rd_req, rd_addr, douta, doutb,
        input  wr_busy, wr_done, rd_gnt, rd_valid, rd_data,
               ena, wea, addra, dina, enb, addrb
    );

endinterface

// File: rtl/bram_port_arbiter_rd_tag_pipe.sv
// rd_tag_pipe: shift register of {valid, ch_id} matching the BRAM read latency.
// Ports: clk, rst (sync, active-high, empties the pipe), tag_in (tag issued
// with the read), tag_out (tag aligned with the BRAM dout of that read).
module rd_tag_pipe
    import bram_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_out
);

    rd_tag_t pipe_r [DEPTH];

    // Shift the tags one stage per cycle; reset drops every in-flight read.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                pipe_r[i] <= '0;
            end
        end else begin
            pipe_r[0] <= tag_in;
            for (int i = 1; i < int'(DEPTH); i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
        end
    end

    assign tag_out = pipe_r[DEPTH-1];

endmodule

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: shares one true-dual-port frame BRAM between a burst
// writer and NUM_CH read channels.
// Ports:
//   clk, rst : system clock, synchronous active-high reset
//   bus      : slave side of bram_port_arbiter_if
//              - writer: wr_valid/wr_last/wr_addr/wr_data in, wr_busy/wr_done out
//              - readers: rd_req/rd_addr in, rd_gnt (combinational), rd_valid/rd_data out
//              - BRAM: ena/wea/addra/dina/enb/addrb out, douta/doutb in
// Port A goes to the writer on every wr_valid beat and is reserved for the
// whole burst; otherwise it serves reads. Port B only serves reads. Read
// data is steered back by a tag pipe per port; the pipe covers RD_LAT
// stages and the rd_valid/rd_data register is the final stage.
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NUM_CH = 3,
    parameter int unsigned RD_LAT = 2
) (
    input  logic               clk,
    input  logic               rst,
    bram_port_arbiter_if.slave bus
);

    localparam logic [CH_ID_W:0] NUM_CH_L = (CH_ID_W+1)'(NUM_CH);

    arb_state_t               state_r;
    arb_state_t               state_nxt_s;
    ch_id_t                   rr_ptr_r;
    ch_id_t                   rr_ptr_nxt_s;
    logic [MAX_CH-1:0]        req_ext_s;
    logic [MAX_CH-1:0]        req_a_ext_s;
    rr_pick_t                 pick_b_s;
    rr_pick_t                 pick_a_s;
    ch_id_t                   start_a_s;
    logic                     porta_free_s;
    logic [NUM_CH-1:0]        gnt_a_s;
    logic [NUM_CH-1:0]        gnt_b_s;
    logic [ADDR_W-1:0]        addr_a_rd_s;
    logic [ADDR_W-1:0]        addr_b_rd_s;
    rd_tag_t                  tag_a_in_s;
    rd_tag_t                  tag_b_in_s;
    rd_tag_t                  tag_a_out_s;
    rd_tag_t                  tag_b_out_s;
    logic                     wr_busy_r;
    logic                     wr_done_r;
    logic                     wr_done_nxt_s;
    logic [NUM_CH-1:0]        rd_valid_r;
    logic [NUM_CH-1:0]        rd_valid_nxt_s;
    logic [NUM_CH*DATA_W-1:0] rd_data_r;
    logic [NUM_CH*DATA_W-1:0] rd_data_nxt_s;

    // Round-robin grant: port B takes the first requester from rr_ptr, port A
    // the next distinct requester after B's pick, and only when the writer is
    // neither active nor holding an open burst.
    always_comb begin
        req_ext_s               = '0;
        req_ext_s[NUM_CH-1:0]   = bus.rd_req;
        porta_free_s            = (state_r == IDLE) && !bus.wr_valid;
        pick_b_s                = rr_pick(req_ext_s, rr_ptr_r, NUM_CH_L);
        start_a_s               = ch_inc(pick_b_s.idx, NUM_CH_L);
        req_a_ext_s             = req_ext_s;
        req_a_ext_s[pick_b_s.idx] = 1'b0;
        pick_a_s                = rr_pick(req_a_ext_s, start_a_s, NUM_CH_L);
        for (int i = 0; i < int'(NUM_CH); i++) begin
            gnt_b_s[i] = !rst && pick_b_s.found && (pick_b_s.idx == ch_id_t'(i));
            gnt_a_s[i] = !rst && porta_free_s && pick_b_s.found && pick_a_s.found &&
                         (pick_a_s.idx == ch_id_t'(i));
        end
    end

    // Pointer moves past the last channel granted this cycle (A's pick follows B's).
    always_comb begin
        if (gnt_a_s != '0) begin
            rr_ptr_nxt_s = ch_inc(pick_a_s.idx, NUM_CH_L);
        end else if (gnt_b_s != '0) begin
            rr_ptr_nxt_s = ch_inc(pick_b_s.idx, NUM_CH_L);
        end else begin
            rr_ptr_nxt_s = rr_ptr_r;
        end
    end

    // Select each port's read address from the granted channel.
    always_comb begin
        addr_a_rd_s = '0;
        addr_b_rd_s = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            addr_a_rd_s = addr_a_rd_s |
                          ({ADDR_W{pick_a_s.idx == ch_id_t'(i)}} & bus.rd_addr[i*ADDR_W +: ADDR_W]);
            addr_b_rd_s = addr_b_rd_s |
                          ({ADDR_W{pick_b_s.idx == ch_id_t'(i)}} & bus.rd_addr[i*ADDR_W +: ADDR_W]);
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state: a burst opens on a non-final beat and closes on wr_last;
    // a lone wr_last beat in IDLE never leaves IDLE.
    always_comb begin
        case (state_r)
            IDLE: begin
                if (bus.wr_valid && !bus.wr_last) begin
                    state_nxt_s = WR_BURST;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WR_BURST: begin
                if (bus.wr_valid && bus.wr_last) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WR_BURST;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM outputs: port A drive and the done strobe for the next cycle.
    always_comb begin
        bus.dina      = bus.wr_data;
        wr_done_nxt_s = bus.wr_valid && bus.wr_last;
        if (rst) begin
            bus.ena   = 1'b0;
            bus.wea   = 1'b0;
            bus.addra = '0;
        end else if (bus.wr_valid) begin
            bus.ena   = 1'b1;
            bus.wea   = 1'b1;
            bus.addra = bus.wr_addr;
        end else if (gnt_a_s != '0) begin
            bus.ena   = 1'b1;
            bus.wea   = 1'b0;
            bus.addra = addr_a_rd_s;
        end else begin
            bus.ena   = 1'b0;
            bus.wea   = 1'b0;
            bus.addra = '0;
        end
    end

    // Writer status flags and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_busy_r <= 1'b0;
            wr_done_r <= 1'b0;
            rr_ptr_r  <= '0;
        end else begin
            wr_busy_r <= (state_nxt_s == WR_BURST);
            wr_done_r <= wr_done_nxt_s;
            rr_ptr_r  <= rr_ptr_nxt_s;
        end
    end

    assign tag_a_in_s.valid = (gnt_a_s != '0);
    assign tag_a_in_s.ch_id = pick_a_s.idx;
    assign tag_b_in_s.valid = (gnt_b_s != '0);
    assign tag_b_in_s.ch_id = pick_b_s.idx;

    rd_tag_pipe #(.DEPTH(RD_LAT)) u_tag_pipe_a (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (tag_a_in_s),
        .tag_out (tag_a_out_s)
    );

    rd_tag_pipe #(.DEPTH(RD_LAT)) u_tag_pipe_b (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (tag_b_in_s),
        .tag_out (tag_b_out_s)
    );

    // Route each port's dout to the channel named by its exiting tag; the two
    // ports never carry the same channel in one cycle.
    always_comb begin
        rd_valid_nxt_s = '0;
        rd_data_nxt_s  = rd_data_r;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (tag_b_out_s.valid && (tag_b_out_s.ch_id == ch_id_t'(i))) begin
                rd_valid_nxt_s[i]                = 1'b1;
                rd_data_nxt_s[i*DATA_W +: DATA_W] = bus.doutb;
            end else if (tag_a_out_s.valid && (tag_a_out_s.ch_id == ch_id_t'(i))) begin
                rd_valid_nxt_s[i]                = 1'b1;
                rd_data_nxt_s[i*DATA_W +: DATA_W] = bus.douta;
            end else begin
                rd_valid_nxt_s[i] = 1'b0;
            end
        end
    end

    // Read return registers; data holds between valid strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_r <= '0;
            rd_data_r  <= '0;
        end else begin
            rd_valid_r <= rd_valid_nxt_s;
            rd_data_r  <= rd_data_nxt_s;
        end
    end

    assign bus.enb      = (gnt_b_s != '0);
    assign bus.addrb    = addr_b_rd_s;
    assign bus.rd_gnt   = gnt_a_s | gnt_b_s;
    assign bus.rd_valid = rd_valid_r;
    assign bus.rd_data  = rd_data_r;
    assign bus.wr_busy  = wr_busy_r;
    assign bus.wr_done  = wr_done_r;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Self-checking bench for bram_port_arbiter (NUM_CH=3, RD_LAT=2) with a
// behavioural two-cycle dual-port BRAM.
module tb_bram_port_arbiter;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int NUM_CH = 3;
    localparam int RD_LAT = 2;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    bram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_CH(NUM_CH)) bus ();

    bram_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_CH(NUM_CH), .RD_LAT(RD_LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural BRAM: address captured at the edge, data out two edges later.
    logic [DATA_W-1:0] mem [0:65535];
    logic [DATA_W-1:0] a_stage;
    logic [DATA_W-1:0] b_stage;
    always @(posedge clk) begin
        if (bus.ena) begin
            if (bus.wea) mem[bus.addra] <= bus.dina;
            a_stage <= mem[bus.addra];
        end
        if (bus.enb) b_stage <= mem[bus.addrb];
        bus.douta <= a_stage;
        bus.doutb <= b_stage;
    end

    function automatic logic [15:0] init_val(input logic [15:0] a);
        return a ^ 16'hA5A5;
    endfunction

    function automatic logic [15:0] rdd(input int ch);
        return bus.rd_data[ch*16 +: 16];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int ch, input logic [15:0] a);
        bus.rd_addr[ch*16 +: 16] = a;
    endtask

    task automatic idle_inputs();
        bus.wr_valid = 1'b0;
        bus.wr_last  = 1'b0;
        bus.wr_addr  = 16'h0000;
        bus.wr_data  = 16'h0000;
        bus.rd_req   = 3'b000;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [2:0] req;
        logic       wv;
        logic       wl;
        logic [2:0] gnt;
        logic       ena;
        logic       wea;
        logic       enb;
        logic [2:0] vld;
    } vec_t;

    vec_t vecs [13];

    initial begin
        // req, wv, wl, gnt, ena, wea, enb, rd_valid (grant of 3 rows earlier)
        vecs[0]  = '{3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000};
        vecs[1]  = '{3'b010, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0, 1'b1, 3'b000};
        vecs[2]  = '{3'b011, 1'b0, 1'b0, 3'b011, 1'b1, 1'b0, 1'b1, 3'b000};
        vecs[3]  = '{3'b111, 1'b0, 1'b0, 3'b101, 1'b1, 1'b0, 1'b1, 3'b000};
        vecs[4]  = '{3'b111, 1'b0, 1'b0, 3'b110, 1'b1, 1'b0, 1'b1, 3'b010};
        vecs[5]  = '{3'b111, 1'b1, 1'b1, 3'b001, 1'b1, 1'b1, 1'b1, 3'b011};
        vecs[6]  = '{3'b100, 1'b0, 1'b0, 3'b100, 1'b0, 1'b0, 1'b1, 3'b101};
        vecs[7]  = '{3'b101, 1'b0, 1'b0, 3'b101, 1'b1, 1'b0, 1'b1, 3'b110};
        vecs[8]  = '{3'b100, 1'b0, 1'b0, 3'b100, 1'b0, 1'b0, 1'b1, 3'b001};
        vecs[9]  = '{3'b001, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0, 1'b1, 3'b100};
        vecs[10] = '{3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'b101};
        vecs[11] = '{3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'b100};
        vecs[12] = '{3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'b001};

        for (int i = 0; i < 65536; i++) mem[i] = init_val(16'(i));
        mem[16'h0010] = 16'hBEEF;
        bus.rd_addr = '0;

        // ---------------- reset state ----------------
        idle_inputs();
        rst = 1'b1;
        bus.rd_req   = 3'b111;
        bus.wr_valid = 1'b1;
        next_cycle();
        @(negedge clk);
        check("rst_gnt",     bus.rd_gnt,   3'b000);
        check("rst_ena",     bus.ena,      1'b0);
        check("rst_wea",     bus.wea,      1'b0);
        check("rst_enb",     bus.enb,      1'b0);
        check("rst_valid",   bus.rd_valid, 3'b000);
        check("rst_data",    bus.rd_data,  48'h0);
        check("rst_busy",    bus.wr_busy,  1'b0);
        check("rst_done",    bus.wr_done,  1'b0);
        next_cycle();
        rst = 1'b0;
        idle_inputs();

        // ---------------- single read ----------------
        bus.rd_req = 3'b010;
        set_addr(1, 16'h0010);
        @(negedge clk);
        check("single_gnt",   bus.rd_gnt, 3'b010);
        check("single_enb",   bus.enb,    1'b1);
        check("single_addrb", bus.addrb,  16'h0010);
        check("single_ena",   bus.ena,    1'b0);
        next_cycle();
        bus.rd_req = 3'b000;
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            check($sformatf("single_novalid%0d", k), bus.rd_valid, 3'b000);
            next_cycle();
        end
        @(negedge clk);
        check("single_valid", bus.rd_valid, 3'b010);
        check("single_data",  rdd(1),       16'hBEEF);
        next_cycle();
        @(negedge clk);
        check("single_valid_drop", bus.rd_valid, 3'b000);
        check("single_data_hold",  rdd(1),       16'hBEEF);

        // ---------------- dual read ----------------
        next_cycle();
        do_reset();
        bus.rd_req = 3'b101;
        set_addr(0, 16'h0020);
        set_addr(2, 16'h0030);
        @(negedge clk);
        check("dual_gnt",   bus.rd_gnt, 3'b101);
        check("dual_addrb", bus.addrb,  16'h0020);
        check("dual_addra", bus.addra,  16'h0030);
        check("dual_ena",   {bus.ena, bus.wea}, 2'b10);
        next_cycle();
        // rr_ptr back at 0: B must take ch0, A ch1
        bus.rd_req = 3'b011;
        set_addr(1, 16'h0040);
        @(negedge clk);
        check("dual_ptr_gnt",   bus.rd_gnt, 3'b011);
        check("dual_ptr_addrb", bus.addrb,  16'h0020);
        check("dual_ptr_addra", bus.addra,  16'h0040);
        next_cycle();
        bus.rd_req = 3'b000;
        next_cycle();
        @(negedge clk);
        check("dual_valid", bus.rd_valid, 3'b101);
        check("dual_data0", rdd(0), init_val(16'h0020));
        check("dual_data2", rdd(2), init_val(16'h0030));
        next_cycle();
        @(negedge clk);
        check("dual_valid2", bus.rd_valid, 3'b011);
        check("dual_data1",  rdd(1), init_val(16'h0040));

        // ---------------- table-driven vectors ----------------
        next_cycle();
        do_reset();
        for (int c = 0; c < NUM_CH; c++) set_addr(c, 16'(16'h0050 + c));
        bus.wr_addr = 16'h0200;
        bus.wr_data = 16'h1234;
        for (int k = 0; k < 13; k++) begin
            bus.rd_req   = vecs[k].req;
            bus.wr_valid = vecs[k].wv;
            bus.wr_last  = vecs[k].wl;
            @(negedge clk);
            check($sformatf("row%0d_gnt", k),   bus.rd_gnt,   vecs[k].gnt);
            check($sformatf("row%0d_ena", k),   bus.ena,      vecs[k].ena);
            check($sformatf("row%0d_wea", k),   bus.wea,      vecs[k].wea);
            check($sformatf("row%0d_enb", k),   bus.enb,      vecs[k].enb);
            check($sformatf("row%0d_valid", k), bus.rd_valid, vecs[k].vld);
            for (int c = 0; c < NUM_CH; c++) begin
                if (vecs[k].vld[c])
                    check($sformatf("row%0d_data%0d", k, c), rdd(c), init_val(16'(16'h0050 + c)));
            end
            next_cycle();
        end
        check("tbl_single_beat_busy", bus.wr_busy, 1'b0);

        // ---------------- fairness under writer ----------------
        do_reset();
        for (int k = 0; k < 7; k++) begin
            logic [2:0] exp_g;
            exp_g = (k % 3 == 0) ? 3'b001 : ((k % 3 == 1) ? 3'b010 : 3'b100);
            bus.wr_valid = 1'b1;
            bus.wr_last  = (k == 6);
            bus.wr_addr  = 16'(16'h0300 + k);
            bus.wr_data  = 16'(16'h5000 + k);
            bus.rd_req   = (k < 6) ? 3'b111 : 3'b000;
            @(negedge clk);
            if (k < 6) check($sformatf("fair%0d_gnt", k), bus.rd_gnt, exp_g);
            check($sformatf("fair%0d_ena", k), {bus.ena, bus.wea}, 2'b11);
            if (k > 0) check($sformatf("fair%0d_busy", k), bus.wr_busy, 1'b1);
            next_cycle();
        end
        idle_inputs();
        @(negedge clk);
        check("fair_done", bus.wr_done, 1'b1);
        check("fair_busy_end", bus.wr_busy, 1'b0);

        // ---------------- write burst with gap ----------------
        next_cycle();
        do_reset();
        bus.wr_valid = 1'b1; bus.wr_addr = 16'h0100; bus.wr_data = 16'hA000;
        @(negedge clk);
        check("wb0_port", {bus.ena, bus.wea}, 2'b11);
        check("wb0_addra", bus.addra, 16'h0100);
        check("wb0_busy", bus.wr_busy, 1'b0);
        next_cycle();
        bus.wr_addr = 16'h0101; bus.wr_data = 16'hA001;
        @(negedge clk);
        check("wb1_busy", bus.wr_busy, 1'b1);
        next_cycle();
        bus.wr_valid = 1'b0;
        bus.rd_req = 3'b011;
        set_addr(0, 16'h0010);
        set_addr(1, 16'h0020);
        @(negedge clk);
        check("wb_gap_ena",  bus.ena,    1'b0);
        check("wb_gap_gnt",  bus.rd_gnt, 3'b001);
        check("wb_gap_busy", bus.wr_busy, 1'b1);
        next_cycle();
        bus.rd_req = 3'b000;
        bus.wr_valid = 1'b1; bus.wr_addr = 16'h0102; bus.wr_data = 16'hA002;
        @(negedge clk);
        check("wb3_busy", bus.wr_busy, 1'b1);
        next_cycle();
        bus.wr_last = 1'b1; bus.wr_addr = 16'h0103; bus.wr_data = 16'hA003;
        @(negedge clk);
        check("wb4_busy", bus.wr_busy, 1'b1);
        check("wb4_done", bus.wr_done, 1'b0);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        check("wb_done",      bus.wr_done,  1'b1);
        check("wb_busy_end",  bus.wr_busy,  1'b0);
        check("wb_gap_valid", bus.rd_valid, 3'b001);
        check("wb_gap_data",  rdd(0),       16'hBEEF);
        next_cycle();
        bus.rd_req = 3'b011;
        set_addr(0, 16'h0100);
        set_addr(1, 16'h0103);
        @(negedge clk);
        check("wb_done_drop", bus.wr_done, 1'b0);
        check("wb_rb_addrb",  bus.addrb,   16'h0103);
        check("wb_rb_addra",  bus.addra,   16'h0100);
        next_cycle();
        set_addr(0, 16'h0101);
        set_addr(1, 16'h0102);
        next_cycle();
        bus.rd_req = 3'b000;
        next_cycle();
        @(negedge clk);
        check("wb_rb_valid0", bus.rd_valid, 3'b011);
        check("wb_rb_d100",   rdd(0), 16'hA000);
        check("wb_rb_d103",   rdd(1), 16'hA003);
        next_cycle();
        @(negedge clk);
        check("wb_rb_valid1", bus.rd_valid, 3'b011);
        check("wb_rb_d101",   rdd(0), 16'hA001);
        check("wb_rb_d102",   rdd(1), 16'hA002);

        // ---------------- single-beat burst ----------------
        next_cycle();
        do_reset();
        bus.wr_valid = 1'b1; bus.wr_last = 1'b1;
        bus.wr_addr = 16'h0400; bus.wr_data = 16'h7777;
        @(negedge clk);
        check("sb_port", {bus.ena, bus.wea}, 2'b11);
        next_cycle();
        idle_inputs();
        bus.rd_req = 3'b011;
        set_addr(0, 16'h0400);
        set_addr(1, 16'h0010);
        @(negedge clk);
        check("sb_done", bus.wr_done, 1'b1);
        check("sb_busy", bus.wr_busy, 1'b0);
        check("sb_idle_gnt", bus.rd_gnt, 3'b011);
        check("sb_idle_ena", {bus.ena, bus.wea}, 2'b10);
        next_cycle();
        bus.rd_req = 3'b000;
        @(negedge clk);
        check("sb_done_drop", bus.wr_done, 1'b0);
        check("sb_busy2", bus.wr_busy, 1'b0);
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("sb_rb_valid", bus.rd_valid, 3'b011);
        check("sb_rb_data0", rdd(0), 16'h7777);
        check("sb_rb_data1", rdd(1), 16'hBEEF);

        // ---------------- reset mid-read ----------------
        next_cycle();
        do_reset();
        bus.rd_req = 3'b100;
        set_addr(2, 16'h0060);
        @(negedge clk);
        check("rmr_gnt", bus.rd_gnt, 3'b100);
        next_cycle();
        bus.rd_req = 3'b100;
        rst = 1'b1;
        @(negedge clk);
        check("rmr_gnt_in_rst", bus.rd_gnt, 3'b000);
        check("rmr_enb_in_rst", bus.enb,    1'b0);
        next_cycle();
        rst = 1'b0;
        bus.rd_req = 3'b000;
        @(negedge clk);
        check("rmr_valid_t2", bus.rd_valid, 3'b000);
        check("rmr_data",     bus.rd_data,  48'h0);
        check("rmr_busy",     bus.wr_busy,  1'b0);
        check("rmr_done",     bus.wr_done,  1'b0);
        next_cycle();
        @(negedge clk);
        check("rmr_valid_t3", bus.rd_valid, 3'b000);
        next_cycle();
        @(negedge clk);
        check("rmr_valid_t4", bus.rd_valid, 3'b000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
